// File: rtl/mem_access.sv
// Load/store stage: single-outstanding 64-bit data-bus access, store lane alignment,
// load extraction/extension and the registered write-back slot for WB.
module mem_access #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [7:0]        inst_type_i,
  input  logic              rd_ena_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [2:0]        ls_sel_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [7:0]        mem_wstrb_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_stall_req_o,
  output logic              wb_valid_o,
  output logic              rd_ena_o,
  output logic [4:0]        rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              misalign_o,
  output logic              bus_err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        off_q;
  logic [2:0]        sel_q;
  logic              is_load_q;
  logic              rd_ena_q;
  logic [4:0]        rd_addr_q;

  logic              is_load;
  logic              is_mem;
  logic              misaligned;
  logic [2:0]        off;
  logic [7:0]        strb_base;
  logic [DATA_W-1:0] ld_raw;
  logic [DATA_W-1:0] ld_data;
  logic              load_done;
  logic              store_done;
  logic              unused_type;

  assign unused_type = ^inst_type_i[7:2];

  assign is_load = inst_type_i[1];
  assign is_mem  = in_valid_i & (inst_type_i[1] | inst_type_i[0]);
  assign off     = ls_addr_i[2:0];

  always_comb begin
    misaligned = 1'b0;
    strb_base  = 8'h01;
    case (ls_sel_i[1:0])
      2'b01: begin misaligned = ls_addr_i[0];    strb_base = 8'h03; end
      2'b10: begin misaligned = |ls_addr_i[1:0]; strb_base = 8'h0F; end
      2'b11: begin misaligned = |ls_addr_i[2:0]; strb_base = 8'hFF; end
      default: begin misaligned = 1'b0;          strb_base = 8'h01; end
    endcase
  end

  always_comb begin
    ld_raw = mem_rdata_i >> {off_q, 3'b000};
    case (sel_q)
      3'b000:  ld_data = {{(DATA_W-8){ld_raw[7]}},   ld_raw[7:0]};
      3'b001:  ld_data = {{(DATA_W-16){ld_raw[15]}}, ld_raw[15:0]};
      3'b010:  ld_data = {{(DATA_W-32){ld_raw[31]}}, ld_raw[31:0]};
      3'b100:  ld_data = {{(DATA_W-8){1'b0}},        ld_raw[7:0]};
      3'b101:  ld_data = {{(DATA_W-16){1'b0}},       ld_raw[15:0]};
      3'b110:  ld_data = {{(DATA_W-32){1'b0}},       ld_raw[31:0]};
      default: ld_data = ld_raw;
    endcase
  end

  // Read data arriving with the ready handshake completes the load without visiting WAIT.
  assign load_done  = is_load_q & mem_rvalid_i &
                      ((state == WAIT) | ((state == REQ) & mem_ready_i));
  assign store_done = ~is_load_q & (state == REQ) & mem_ready_i;

  // Stall is forced low while in reset so every output reads 0 during an abort.
  assign mem_stall_req_o = ~rst & ((state == REQ) | (state == WAIT) |
                                   ((state == IDLE) & is_mem & ~misaligned));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      off_q       <= '0;
      sel_q       <= '0;
      is_load_q   <= 1'b0;
      rd_ena_q    <= 1'b0;
      rd_addr_q   <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wstrb_o <= '0;
      wb_valid_o  <= 1'b0;
      rd_ena_o    <= 1'b0;
      rd_addr_o   <= '0;
      rd_data_o   <= '0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (is_mem && !misaligned) begin
            state       <= REQ;
            cnt         <= '0;
            off_q       <= off;
            sel_q       <= ls_sel_i;
            is_load_q   <= is_load;
            rd_ena_q    <= rd_ena_i;
            rd_addr_q   <= rd_addr_i;
            mem_req_o   <= 1'b1;
            mem_we_o    <= ~is_load;
            mem_addr_o  <= {ls_addr_i[ADDR_W-1:3], 3'b000};
            mem_wdata_o <= rd_data_i << {off, 3'b000};
            mem_wstrb_o <= is_load ? 8'h00 : (strb_base << off);
            wb_valid_o  <= 1'b0;
            rd_ena_o    <= 1'b0;
          end else if (is_mem) begin
            misalign_o <= 1'b1;
            wb_valid_o <= 1'b1;
            rd_ena_o   <= 1'b0;
            rd_addr_o  <= rd_addr_i;
            rd_data_o  <= '0;
          end else if (in_valid_i) begin
            wb_valid_o <= 1'b1;
            rd_ena_o   <= rd_ena_i;
            rd_addr_o  <= rd_addr_i;
            rd_data_o  <= rd_data_i;
          end else begin
            wb_valid_o <= 1'b0;
            rd_ena_o   <= 1'b0;
          end
        end
        REQ, WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if ((state == REQ) && mem_ready_i) begin
            mem_req_o <= 1'b0;
          end
          if (load_done || store_done) begin
            state      <= DONE;
            wb_valid_o <= 1'b1;
            rd_ena_o   <= is_load_q & rd_ena_q;
            rd_addr_o  <= rd_addr_q;
            if (is_load_q) begin
              rd_data_o <= ld_data;
            end
          end else if ((state == REQ) && mem_ready_i) begin
            state <= WAIT;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= DONE;
            mem_req_o  <= 1'b0;
            bus_err_o  <= 1'b1;
            wb_valid_o <= 1'b1;
            rd_ena_o   <= 1'b0;
            rd_addr_o  <= rd_addr_q;
            rd_data_o  <= '0;
          end
        end
        default: begin
          // DONE: upstream advances on this edge, so the input now visible is not re-issued.
          state      <= IDLE;
          wb_valid_o <= 1'b0;
          rd_ena_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: scoreboard of expected write-back slots plus
// bus-side checks for lanes, strobes, stall length, timeout and reset abort.
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic [7:0]  inst_type_i;
  logic        rd_ena_i;
  logic [4:0]  rd_addr_i;
  logic [63:0] rd_data_i;
  logic [2:0]  ls_sel_i;
  logic [63:0] ls_addr_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        mem_stall_req_o;
  logic        wb_valid_o;
  logic        rd_ena_o;
  logic [4:0]  rd_addr_o;
  logic [63:0] rd_data_o;
  logic        misalign_o;
  logic        bus_err_o;

  mem_access #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .inst_type_i(inst_type_i), .rd_ena_i(rd_ena_i),
    .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .ls_sel_i(ls_sel_i), .ls_addr_i(ls_addr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_stall_req_o(mem_stall_req_o),
    .wb_valid_o(wb_valid_o), .rd_ena_o(rd_ena_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ena;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        mis;
    logic        err;
    bit          chk;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  int          stall_cycles, req_cycles;
  bit          got_wb, unstable;
  logic        obs_ena, obs_mis, obs_err, obs_stall, after_req, after_wb, after_err;
  logic [4:0]  obs_addr;
  logic [63:0] obs_data;
  logic        cap_we;
  logic [63:0] cap_addr, cap_wdata;
  logic [7:0]  cap_wstrb;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] t, input logic [2:0] sel, input logic [63:0] a,
                       input logic [4:0] rd, input logic [63:0] d);
    in_valid_i  = 1'b1;
    inst_type_i = t;
    rd_ena_i    = 1'b1;
    rd_addr_i   = rd;
    rd_data_i   = d;
    ls_sel_i    = sel;
    ls_addr_i   = a;
  endtask

  // Cycle 0 is the IDLE cycle with the instruction already presented; the bus answers
  // ready on cycle rdy_at and rvalid on cycle rv_at. Also retires the DONE cycle.
  task automatic run_access(input int rdy_at, input int rv_at, input logic [63:0] rdata,
                            input int limit);
    bit have_cap;
    stall_cycles = 0; req_cycles = 0; got_wb = 0; unstable = 0; have_cap = 0;
    for (int cyc = 0; cyc < limit && !got_wb; cyc++) begin
      #1;
      if (mem_stall_req_o) stall_cycles++;
      if (mem_req_o) begin
        req_cycles++;
        if (have_cap && ({cap_we, cap_addr, cap_wdata, cap_wstrb} !==
                         {mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o})) unstable = 1;
        cap_we = mem_we_o; cap_addr = mem_addr_o; cap_wdata = mem_wdata_o; cap_wstrb = mem_wstrb_o;
        have_cap = 1;
      end
      mem_ready_i  = (cyc == rdy_at);
      mem_rvalid_i = (cyc == rv_at);
      mem_rdata_i  = (cyc == rv_at) ? rdata : ~rdata;
      step();
      mem_ready_i  = 1'b0;
      mem_rvalid_i = 1'b0;
      if (wb_valid_o) begin
        got_wb = 1;
        obs_ena = rd_ena_o; obs_addr = rd_addr_o; obs_data = rd_data_o;
        obs_mis = misalign_o; obs_err = bus_err_o; obs_stall = mem_stall_req_o;
      end
    end
    if (got_wb) begin
      step();
      after_req = mem_req_o; after_wb = wb_valid_o; after_err = bus_err_o;
    end
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid_i = 0; inst_type_i = 0; rd_ena_i = 0; rd_addr_i = 0; rd_data_i = 0;
    ls_sel_i = 0; ls_addr_i = 0; mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    repeat (2) step();
    checks++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_stall_req_o, wb_valid_o,
         rd_ena_o, rd_addr_o, rd_data_o, misalign_o, bus_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b wb=%b rd_ena=%b rd_data=%h stall=%b, required all 0",
               mem_req_o, wb_valid_o, rd_ena_o, rd_data_o, mem_stall_req_o);
    end
    rst = 1'b0;
    step();
  endtask

  typedef struct {
    logic [7:0]  itype;
    logic [2:0]  sel;
    logic [63:0] addr;
    logic [63:0] rdata;
    int          rdy;
    int          rv;
    logic [63:0] exp;
  } ld_t;

  task automatic test_loads();
    ld_t  t[9];
    exp_t e;
    int   exp_stall;
    t[0] = '{8'h02, 3'd3, 64'h80001008, 64'h1122334455667788, 2, 4, 64'h1122334455667788};
    t[1] = '{8'h02, 3'd0, 64'h80000003, 64'h0000000080000000, 1, 2, 64'hFFFFFFFFFFFFFF80};
    t[2] = '{8'h03, 3'd4, 64'h80000003, 64'h0000000080000000, 1, 2, 64'h0000000000000080};
    t[3] = '{8'h02, 3'd1, 64'h80000002, 64'h0000000080010000, 1, 1, 64'hFFFFFFFFFFFF8001};
    t[4] = '{8'h02, 3'd5, 64'h80000002, 64'h0000000080010000, 1, 3, 64'h0000000000008001};
    t[5] = '{8'h02, 3'd2, 64'h80000004, 64'h8000000100000000, 3, 3, 64'hFFFFFFFF80000001};
    t[6] = '{8'h02, 3'd6, 64'h80000004, 64'h8000000100000000, 1, 2, 64'h0000000080000001};
    t[7] = '{8'h02, 3'd7, 64'h80000018, 64'hDEADBEEFCAFEF00D, 1, 2, 64'hDEADBEEFCAFEF00D};
    t[8] = '{8'h02, 3'd0, 64'h80000007, 64'h7F00000000000000, 2, 2, 64'h000000000000007F};
    for (int i = 0; i < 9; i++) begin
      drive(t[i].itype, t[i].sel, t[i].addr, 5'(i + 1), 64'hFEEDFACE0BADF00D);
      sb.push_back('{1'b1, 5'(i + 1), t[i].exp, 1'b0, 1'b0, 1'b1});
      exp_stall = (t[i].rv > t[i].rdy) ? t[i].rv + 1 : t[i].rdy + 1;
      run_access(t[i].rdy, t[i].rv, t[i].rdata, 20);
      e = sb.pop_front();
      checks++;
      if (!got_wb) begin
        errors++; $display("FAIL load%0d_wb: no wb_valid within 20 cycles, required one", i);
      end else if (obs_ena !== e.ena || obs_mis !== e.mis || obs_err !== e.err ||
                   obs_addr !== e.addr || obs_data !== e.data) begin
        errors++;
        $display("FAIL load%0d_wb: ena=%b rd=%0d data=%h mis=%b err=%b, required ena=%b rd=%0d data=%h mis=%b err=%b",
                 i, obs_ena, obs_addr, obs_data, obs_mis, obs_err, e.ena, e.addr, e.data, e.mis, e.err);
      end
      checks++;
      if ({cap_we, cap_addr} !== {1'b0, t[i].addr & ~64'h7} || unstable) begin
        errors++;
        $display("FAIL load%0d_bus: we=%b addr=%h unstable=%b, required we=0 addr=%h stable",
                 i, cap_we, cap_addr, unstable, t[i].addr & ~64'h7);
      end
      checks++;
      if (stall_cycles != exp_stall || req_cycles != t[i].rdy) begin
        errors++;
        $display("FAIL load%0d_timing: stall=%0d req=%0d, required stall=%0d req=%0d",
                 i, stall_cycles, req_cycles, exp_stall, t[i].rdy);
      end
      checks++;
      if ({obs_stall, after_req, after_wb} !== 3'b000) begin
        errors++;
        $display("FAIL load%0d_done: stall=%b req_after=%b wb_after=%b, required 0 0 0",
                 i, obs_stall, after_req, after_wb);
      end
    end
  endtask

  task automatic test_timeout();
    int   rdy[2]   = '{-1, 1};
    int   ereq[2]  = '{255, 1};
    int   estall[2] = '{256, 257};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(8'h02, 3'd3, 64'h80000040, 5'd20, 64'h0123456789ABCDEF);
      sb.push_back('{1'b0, 5'd20, 64'h0, 1'b0, 1'b1, 1'b1});
      run_access(rdy[i], -1, 64'h5555AAAA5555AAAA, 300);
      e = sb.pop_front();
      checks++;
      if (!got_wb) begin
        errors++; $display("FAIL timeout%0d_wb: no abort within 300 cycles, required one", i);
      end else if (obs_ena !== e.ena || obs_mis !== e.mis || obs_err !== e.err || obs_data !== e.data) begin
        errors++;
        $display("FAIL timeout%0d_wb: ena=%b data=%h mis=%b err=%b, required ena=0 data=0 mis=0 err=1",
                 i, obs_ena, obs_data, obs_mis, obs_err);
      end
      checks++;
      if (req_cycles != ereq[i] || stall_cycles != estall[i]) begin
        errors++;
        $display("FAIL timeout%0d_timing: req=%0d stall=%0d, required req=%0d stall=%0d",
                 i, req_cycles, stall_cycles, ereq[i], estall[i]);
      end
      checks++;
      if ({obs_stall, after_req, after_err} !== 3'b000) begin
        errors++;
        $display("FAIL timeout%0d_release: stall=%b req_after=%b err_after=%b, required 0 0 0",
                 i, obs_stall, after_req, after_err);
      end
    end
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          rdy;
  } st_t;

  task automatic test_stores();
    st_t  t[5];
    exp_t e;
    t[0] = '{3'd1, 64'h80000006, 64'h000000000000ABCD, 64'hABCD000000000000, 8'hC0, 1};
    t[1] = '{3'd0, 64'h80000005, 64'h0000000000000012, 64'h0000120000000000, 8'h20, 3};
    t[2] = '{3'd2, 64'h80000004, 64'h0000000089ABCDEF, 64'h89ABCDEF00000000, 8'hF0, 1};
    t[3] = '{3'd3, 64'h80000100, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 8'hFF, 2};
    t[4] = '{3'd0, 64'h80000000, 64'h000000000000005A, 64'h000000000000005A, 8'h01, 1};
    for (int i = 0; i < 5; i++) begin
      drive(8'h01, t[i].sel, t[i].addr, 5'd7, t[i].data);
      sb.push_back('{1'b0, 5'd7, 64'h0, 1'b0, 1'b0, 1'b0});
      run_access(t[i].rdy, -1, 64'h0, 20);
      e = sb.pop_front();
      checks++;
      if (!got_wb) begin
        errors++; $display("FAIL store%0d_wb: no wb_valid within 20 cycles, required one", i);
      end else if (obs_ena !== e.ena || obs_mis !== e.mis || obs_err !== e.err) begin
        errors++;
        $display("FAIL store%0d_wb: ena=%b mis=%b err=%b, required ena=0 mis=0 err=0",
                 i, obs_ena, obs_mis, obs_err);
      end
      checks++;
      if ({cap_we, cap_addr, cap_wdata, cap_wstrb} !==
          {1'b1, t[i].addr & ~64'h7, t[i].wdata, t[i].wstrb} || unstable) begin
        errors++;
        $display("FAIL store%0d_bus: we=%b addr=%h wdata=%h wstrb=%h unstable=%b, required we=1 addr=%h wdata=%h wstrb=%h",
                 i, cap_we, cap_addr, cap_wdata, cap_wstrb, unstable,
                 t[i].addr & ~64'h7, t[i].wdata, t[i].wstrb);
      end
      checks++;
      if (stall_cycles != t[i].rdy + 1 || req_cycles != t[i].rdy || after_req !== 1'b0) begin
        errors++;
        $display("FAIL store%0d_timing: stall=%0d req=%0d req_after=%b, required stall=%0d req=%0d req_after=0",
                 i, stall_cycles, req_cycles, after_req, t[i].rdy + 1, t[i].rdy);
      end
    end
  endtask

  task automatic test_misalign();
    logic [7:0]  ty[4] = '{8'h02, 8'h02, 8'h02, 8'h01};
    logic [2:0]  sl[4] = '{3'd2, 3'd5, 3'd3, 3'd2};
    logic [63:0] ad[4] = '{64'h80000002, 64'h80000001, 64'h80000004, 64'h80000006};
    exp_t e;
    logic stall0;
    for (int i = 0; i < 4; i++) begin
      drive(ty[i], sl[i], ad[i], 5'd9, 64'h1111);
      sb.push_back('{1'b0, 5'd9, 64'h0, 1'b1, 1'b0, 1'b0});
      #1;
      stall0 = mem_stall_req_o;
      step();
      in_valid_i = 1'b0;
      e = sb.pop_front();
      checks++;
      if (wb_valid_o !== 1'b1 || rd_ena_o !== e.ena || misalign_o !== e.mis || bus_err_o !== e.err) begin
        errors++;
        $display("FAIL misalign%0d_wb: wb=%b ena=%b mis=%b err=%b, required wb=1 ena=0 mis=1 err=0",
                 i, wb_valid_o, rd_ena_o, misalign_o, bus_err_o);
      end
      checks++;
      if ({stall0, mem_req_o} !== 2'b00) begin
        errors++;
        $display("FAIL misalign%0d_nobus: stall=%b req=%b, required 0 0", i, stall0, mem_req_o);
      end
      step();
      checks++;
      if ({misalign_o, wb_valid_o, mem_req_o} !== 3'b000) begin
        errors++;
        $display("FAIL misalign%0d_pulse: mis=%b wb=%b req=%b, required 0 0 0",
                 i, misalign_o, wb_valid_o, mem_req_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drive(8'h04, 3'd0, 64'h80000002, 5'd10, 64'h5);
    sb.push_back('{1'b1, 5'd10, 64'h5, 1'b0, 1'b0, 1'b1});
    #1;
    checks++;
    if (mem_stall_req_o !== 1'b0) begin
      errors++; $display("FAIL b2b_alu_stall: stall=%b, required 0", mem_stall_req_o);
    end
    step();
    e = sb.pop_front();
    checks++;
    if (wb_valid_o !== 1'b1 || rd_ena_o !== e.ena || rd_addr_o !== e.addr || rd_data_o !== e.data ||
        misalign_o !== e.mis || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_alu_wb: wb=%b ena=%b rd=%0d data=%h mis=%b req=%b, required wb=1 ena=1 rd=10 data=5 mis=0 req=0",
               wb_valid_o, rd_ena_o, rd_addr_o, rd_data_o, misalign_o, mem_req_o);
    end
    drive(8'h02, 3'd2, 64'h80000010, 5'd11, 64'h0);
    sb.push_back('{1'b1, 5'd11, 64'hFFFFFFFF80000000, 1'b0, 1'b0, 1'b1});
    run_access(1, 1, 64'h0000000080000000, 20);
    e = sb.pop_front();
    checks++;
    if (!got_wb || obs_ena !== e.ena || obs_addr !== e.addr || obs_data !== e.data || obs_mis !== e.mis) begin
      errors++;
      $display("FAIL b2b_lw_wb: got=%b ena=%b rd=%0d data=%h mis=%b, required got=1 ena=1 rd=11 data=%h mis=0",
               got_wb, obs_ena, obs_addr, obs_data, obs_mis, e.data);
    end
    checks++;
    if (req_cycles != 1 || stall_cycles != 2 || after_req !== 1'b0 || after_wb !== 1'b0) begin
      errors++;
      $display("FAIL b2b_lw_once: req=%0d stall=%0d req_after=%b wb_after=%b, required 1 2 0 0",
               req_cycles, stall_cycles, after_req, after_wb);
    end
  endtask

  task automatic test_reset_mid();
    drive(8'h02, 3'd3, 64'h80000080, 5'd3, 64'h0);
    step();
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++; $display("FAIL rstreq_pre: req=%b, required 1", mem_req_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || mem_stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL rstreq_async: req=%b stall=%b, required 0 0", mem_req_o, mem_stall_req_o);
    end
    step();
    rst = 1'b0;
    step();
    mem_ready_i = 1'b1;
    step();
    mem_ready_i = 1'b0;
    step();
    checks++;
    if ({mem_stall_req_o, mem_req_o} !== 2'b10) begin
      errors++;
      $display("FAIL rstwait_pre: stall=%b req=%b, required stall=1 req=0", mem_stall_req_o, mem_req_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_stall_req_o, wb_valid_o,
         rd_ena_o, rd_addr_o, rd_data_o, misalign_o, bus_err_o} !== '0) begin
      errors++;
      $display("FAIL rstwait_outputs: req=%b addr=%h stall=%b wb=%b rd_data=%h, required all 0",
               mem_req_o, mem_addr_o, mem_stall_req_o, wb_valid_o, rd_data_o);
    end
    in_valid_i = 1'b0;
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({mem_req_o, wb_valid_o, mem_stall_req_o} !== 3'b000) begin
      errors++;
      $display("FAIL rst_release: req=%b wb=%b stall=%b, required 0 0 0",
               mem_req_o, wb_valid_o, mem_stall_req_o);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_loads();
    test_timeout();
    test_stores();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
